// File: rtl/usb_rx_pkg.sv
// Shared types and default constants for the USB receive controller.
package usb_rx_pkg;

    localparam int NUM_BITS       = 8;
    localparam int STUFF_LIMIT    = 6;
    localparam int SYNC_MIN_ZEROS = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC_HUNT = 2'd1,
        RECEIVE   = 2'd2,
        DRAIN     = 2'd3
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter that runs 0..rollover_val-1 and flags the wrapping increment.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    w_last;

    assign w_last        = (r_count == rollover_val - 1'b1);
    assign rollover_flag = count_enable & ~clear & w_last;
    assign count_out     = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive control: SYNC hunt, bit-unstuffing and byte/packet framing
// for a decoded bit stream feeding an external serial-to-parallel register.
module usb_rx_ctrl #(
    parameter int NUM_BITS       = usb_rx_pkg::NUM_BITS,
    parameter int STUFF_LIMIT    = usb_rx_pkg::STUFF_LIMIT,
    parameter int SYNC_MIN_ZEROS = usb_rx_pkg::SYNC_MIN_ZEROS
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_valid,
    input  logic d_bit,
    input  logic eop,
    output logic shift_enable,
    output logic rx_active,
    output logic byte_ready,
    output logic rx_done,
    output logic rx_error
);

    import usb_rx_pkg::*;

    localparam int BC_W = $clog2(NUM_BITS + 1);
    localparam int OC_W = $clog2(STUFF_LIMIT + 1);
    localparam int ZC_W = $clog2(SYNC_MIN_ZEROS + 1);

    state_t            r_state, w_next;
    logic [ZC_W-1:0]   r_zeros, w_zeros_nx;
    logic [OC_W-1:0]   r_ones, w_ones_nx;
    logic [BC_W-1:0]   w_bit_cnt;
    logic              w_sync_det, w_done_nx, w_err_nx;
    logic              w_stuff, w_wrap, w_bit;
    logic              r_active, r_byte, r_done, r_err;

    assign w_stuff      = (r_ones == OC_W'(STUFF_LIMIT));
    assign w_bit        = d_valid & ~eop;
    assign shift_enable = w_bit & (r_state == RECEIVE) & ~w_stuff;

    flex_counter #(
        .NUM_CNT_BITS (BC_W)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_sync_det),
        .count_enable  (shift_enable),
        .rollover_val  (BC_W'(NUM_BITS)),
        .count_out     (w_bit_cnt),
        .rollover_flag (w_wrap)
    );

    always_comb begin
        w_next     = r_state;
        w_zeros_nx = r_zeros;
        w_ones_nx  = r_ones;
        w_sync_det = 1'b0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bit && !d_bit) begin
                    w_next     = SYNC_HUNT;
                    w_zeros_nx = ZC_W'(1);
                end
            end
            SYNC_HUNT: begin
                if (eop) begin
                    w_next = IDLE;
                end else if (d_valid && !d_bit) begin
                    if (r_zeros < ZC_W'(SYNC_MIN_ZEROS))
                        w_zeros_nx = r_zeros + 1'b1;
                end else if (d_valid) begin
                    if (r_zeros >= ZC_W'(SYNC_MIN_ZEROS)) begin
                        w_next     = RECEIVE;
                        w_sync_det = 1'b1;
                        // SYNC's closing 1 counts toward the stuffing run
                        w_ones_nx  = OC_W'(1);
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            RECEIVE: begin
                if (eop) begin
                    w_next    = IDLE;
                    w_done_nx = (w_bit_cnt == '0);
                    w_err_nx  = (w_bit_cnt != '0);
                end else if (d_valid && w_stuff) begin
                    if (d_bit) begin
                        w_err_nx = 1'b1;
                        w_next   = DRAIN;
                    end else begin
                        w_ones_nx = '0;
                    end
                end else if (d_valid) begin
                    w_ones_nx = d_bit ? r_ones + 1'b1 : '0;
                end
            end
            DRAIN: begin
                if (eop)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_zeros  <= '0;
            r_ones   <= '0;
            r_active <= 1'b0;
            r_byte   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_zeros  <= w_zeros_nx;
            r_ones   <= w_ones_nx;
            r_active <= (w_next == RECEIVE) || (w_next == DRAIN);
            r_byte   <= w_wrap;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
        end
    end

    assign rx_active  = r_active;
    assign byte_ready = r_byte;
    assign rx_done    = r_done;
    assign rx_error   = r_err;

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8: data bits per received byte.
REQ-002 SHALL have parameter STUFF_LIMIT, default 6: consecutive data 1s after which one stuffed 0 follows.
REQ-003 SHALL have parameter SYNC_MIN_ZEROS, default 5: minimum decoded 0s before the SYNC-terminating 1.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port d_valid  input  1  one-cycle strobe marking a new NRZI-decoded bit on d_bit.
REQ-007 SHALL have port d_bit  input  1  decoded bit, sampled only when d_valid=1; also wired to the shift register serial_in.
REQ-008 SHALL have port eop  input  1  one-cycle end-of-packet (SE0) strobe.
REQ-009 SHALL have port shift_enable  output  1  drives the LSB-first (SHIFT_MSB=0) NUM_BITS serial-to-parallel shift register.
REQ-010 SHALL have port rx_active  output  1  high from SYNC detection until return to IDLE.
REQ-011 SHALL have port byte_ready  output  1  one-cycle pulse: shift register parallel_out holds a complete byte.
REQ-012 SHALL have port rx_done  output  1  one-cycle pulse: packet ended cleanly on a byte boundary.
REQ-013 SHALL have port rx_error  output  1  one-cycle pulse: stuff error or EOP mid-byte.

Function
REQ-014 SHALL implement states IDLE, SYNC_HUNT, RECEIVE, DRAIN.
REQ-015 IDLE -> SYNC_HUNT on first d_valid with d_bit=0; zero counter loads 1.
REQ-016 SYNC_HUNT: each valid 0 increments zero counter, saturating at SYNC_MIN_ZEROS; valid 1 with counter >= SYNC_MIN_ZEROS -> RECEIVE; valid 1 with counter < SYNC_MIN_ZEROS -> IDLE, no pulses.
REQ-017 On SYNC_HUNT -> RECEIVE: bit count = 0, ones count = 1 (SYNC 1 counts toward stuffing).
REQ-018 shift_enable SHALL be combinational: d_valid & (state==RECEIVE) & ~eop & ~(ones count==STUFF_LIMIT), i.e. same cycle as the data bit.
REQ-019 RECEIVE, valid data bit: ones count increments on 1, clears on 0; bit count increments, wrapping NUM_BITS-1 -> 0.
REQ-020 Bit-count wrap SHALL raise byte_ready, registered, exactly 1 cycle after the shifting cycle.
REQ-021 RECEIVE, valid bit with ones count==STUFF_LIMIT: d_bit=0 -> dropped (no shift, bit count unchanged, ones count=0); d_bit=1 -> rx_error pulse, -> DRAIN.
REQ-022 RECEIVE, eop: bit count==0 -> rx_done pulse next cycle; else rx_error pulse next cycle; both -> IDLE.
REQ-023 eop and d_valid same cycle: eop wins, bit ignored, shift_enable=0.
REQ-024 eop in SYNC_HUNT -> IDLE, no pulses; eop in IDLE ignored.
REQ-025 DRAIN: all bits ignored, shift_enable=0; eop -> IDLE, no further pulses.
REQ-026 rx_active SHALL be registered, high in RECEIVE and DRAIN only.
REQ-027 byte_ready, rx_done, rx_error SHALL be mutually exclusive in any cycle and never longer than one cycle.

Reset
REQ-028 n_rst low SHALL force state IDLE, all counters 0, all registered outputs 0, immediately and regardless of clk.
REQ-029 Reset mid-packet SHALL not emit rx_done, rx_error or byte_ready on release; next packet requires a fresh SYNC.

Structure
REQ-030 Shared package usb_rx_pkg SHALL hold the state enum and the default constants NUM_BITS, STUFF_LIMIT, SYNC_MIN_ZEROS.
REQ-031 Bit count SHALL be one flex_counter instance (rollover NUM_BITS, clear on SYNC detect); all other logic inline.

Verification
REQ-032 SYNC (7 zeros, 1), byte 0xA5 LSB first, eop -> shift_enable high on 8 strobes, byte_ready once 1 cycle after 8th, rx_done once, rx_error never.
REQ-033 After SYNC: 5 data 1s then stuffed 0, then 0,0 -> 6th valid bit produces no shift_enable; byte completes after 8 non-stuffed bits.
REQ-034 After SYNC: 5 data 1s then a 1 -> rx_error pulse, state DRAIN, no byte_ready; eop -> IDLE.
REQ-035 SYNC, 3 data bits, eop -> rx_error pulse, rx_done 0, byte_ready 0, rx_active low next cycle.
REQ-036 Only 3 zeros then 1 -> stays IDLE, rx_active 0, shift_enable 0 for following bits until valid SYNC.
REQ-037 n_rst low after 4 data bits, released, eop -> no pulses; new SYNC + 0x3C -> byte_ready once, rx_done once.
